// File: rtl/stager_pkg.sv
// stager_pkg: tile geometry, mode bit positions and bank-state encoding for operand_stager
package stager_pkg;
  localparam int LANE_W    = 264;
  localparam int ROWS      = 16;
  localparam int BEATS     = ROWS + 1;
  localparam int IDX_W     = $clog2(BEATS);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int MODE_INT8 = 0;
  localparam int MODE_INT4 = 1;
  localparam int MODE_VSQ  = 2;
  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_ISSUED} bank_state_e;
endpackage

// File: rtl/stager_bank.sv
// stager_bank: one ping-pong bank holding a tile's A rows, B vector, mode and lifecycle state
module stager_bank
  import stager_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [LANE_W-1:0]      wr_data,
  input  logic                   wr_last,
  input  logic [2:0]             wr_mode,
  input  logic                   issue,
  input  logic                   rel,
  output bank_state_e            state,
  output logic [ROWS*LANE_W-1:0] a_rows,
  output logic [LANE_W-1:0]      b_row,
  output logic [2:0]             mode,
  output logic                   tile_done,
  output logic                   frame_err,
  output logic                   mode_err
);
  bank_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2:0]        mode_q, mode_d;
  logic [LANE_W-1:0] rows_q [ROWS];
  logic [LANE_W-1:0] rows_d [ROWS];
  logic [LANE_W-1:0] b_q, b_d;
  logic              at_b;
  assign at_b = idx_q == IDX_W'(ROWS);
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    rows_d    = rows_q;
    b_d       = b_q;
    tile_done = 1'b0;
    frame_err = 1'b0;
    mode_err  = 1'b0;
    if (wr_en && (wr_last != at_b)) begin
      frame_err = 1'b1;
      state_d   = BANK_EMPTY;
      idx_d     = '0;
    end else if (wr_en && at_b) begin
      b_d       = wr_data;
      tile_done = 1'b1;
      state_d   = BANK_FULL;
      idx_d     = '0;
    end else if (wr_en) begin
      rows_d[idx_q[ROW_W-1:0]] = wr_data;
      idx_d   = idx_q + 1'b1;
      state_d = BANK_FILLING;
      if (idx_q == '0) begin
        mode_err          = wr_mode[MODE_INT8] & wr_mode[MODE_INT4];
        mode_d            = wr_mode;
        mode_d[MODE_INT4] = wr_mode[MODE_INT4] & ~wr_mode[MODE_INT8];
      end
    end
    if (issue) state_d = BANK_ISSUED;
    if (rel) state_d = BANK_EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BANK_EMPTY;
      idx_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end
  // payload is never visible before its first launch, so it needs no reset
  always_ff @(posedge clk) begin
    rows_q <= rows_d;
    b_q    <= b_d;
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign a_rows[r*LANE_W +: LANE_W] = rows_q[r];
  end
  assign state = state_q;
  assign b_row = b_q;
  assign mode  = mode_q;
endmodule

// File: rtl/operand_stager.sv
// operand_stager: ping-pong tile stager for the matrix engine; OPERAND_STAGER_PERF_EN adds stall/idle counters
module operand_stager
  import stager_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANE_W-1:0]      in_data,
  input  logic                   in_last,
  input  logic [2:0]             cfg_mode,
  output logic [ROWS*LANE_W-1:0] a_vec,
  output logic [LANE_W-1:0]      b_vec,
  output logic                   is_int8_mode,
  output logic                   is_int4_mode,
  output logic                   is_vsq,
  output logic                   valid_mac,
  input  logic                   calc_done,
  output logic                   busy,
  output logic                   err
`ifdef OPERAND_STAGER_PERF_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            idle_cnt
`endif
);
  bank_state_e            st   [2];
  logic [ROWS*LANE_W-1:0] rows [2];
  logic [LANE_W-1:0]      bv   [2];
  logic [2:0]             md   [2];
  logic [1:0]             done, fe, me;
  logic fill_q, fill_d, iss_q, iss_d, busy_q, busy_d;
  logic disp_q, disp_d, shown_q, shown_d, err_q, err_d;
  logic launch, sel, vis;
  for (genvar i = 0; i < 2; i++) begin : g_bank
    stager_bank u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (in_valid && in_ready && (fill_q == 1'(i))),
      .wr_data   (in_data),
      .wr_last   (in_last),
      .wr_mode   (cfg_mode),
      .issue     (launch && (iss_q == 1'(i))),
      .rel       (calc_done && busy_q && (st[i] == BANK_ISSUED)),
      .state     (st[i]),
      .a_rows    (rows[i]),
      .b_row     (bv[i]),
      .mode      (md[i]),
      .tile_done (done[i]),
      .frame_err (fe[i]),
      .mode_err  (me[i])
    );
  end
  // the launched bank stays on the outputs until the next launch, even after it drains
  always_comb begin
    launch  = (st[iss_q] == BANK_FULL) && !busy_q;
    sel     = launch ? iss_q : disp_q;
    vis     = shown_q | launch;
    fill_d  = fill_q ^ (|done);
    iss_d   = iss_q ^ launch;
    busy_d  = launch | (busy_q & ~calc_done);
    disp_d  = sel;
    shown_d = vis;
    err_d   = err_q | (|fe) | (|me);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= 1'b0;
      iss_q   <= 1'b0;
      busy_q  <= 1'b0;
      disp_q  <= 1'b0;
      shown_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      iss_q   <= iss_d;
      busy_q  <= busy_d;
      disp_q  <= disp_d;
      shown_q <= shown_d;
      err_q   <= err_d;
    end
  end
  assign in_ready     = (st[fill_q] == BANK_EMPTY) || (st[fill_q] == BANK_FILLING);
  assign valid_mac    = launch;
  assign busy         = busy_q | launch;
  assign err          = err_q;
  assign a_vec        = vis ? rows[sel] : '0;
  assign b_vec        = vis ? bv[sel] : '0;
  assign is_int8_mode = vis & md[sel][MODE_INT8];
  assign is_int4_mode = vis & md[sel][MODE_INT4];
  assign is_vsq       = vis & md[sel][MODE_VSQ];
`ifdef OPERAND_STAGER_PERF_EN
  logic [31:0] stall_q, stall_d, idle_q, idle_d;
  always_comb begin
    stall_d = stall_q + 32'(in_valid && !in_ready && (stall_q != '1));
    idle_d  = idle_q + 32'(!busy && (st[0] != BANK_FULL) && (st[1] != BANK_FULL) && (idle_q != '1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      idle_q  <= '0;
    end else begin
      stall_q <= stall_d;
      idle_q  <= idle_d;
    end
  end
  assign stall_cnt = stall_q;
  assign idle_cnt  = idle_q;
`endif
endmodule

// File: tb/tb_operand_stager.sv
// tb_operand_stager: table vectors, directed corner sequences and random traffic against a tile-queue model
module tb_operand_stager;
  import stager_pkg::*;
  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [LANE_W-1:0]      in_data = '0;
  logic                   in_last = 1'b0;
  logic [2:0]             cfg_mode = '0;
  logic [ROWS*LANE_W-1:0] a_vec;
  logic [LANE_W-1:0]      b_vec;
  logic                   is_int8_mode, is_int4_mode, is_vsq;
  logic                   valid_mac;
  logic                   calc_done = 1'b0;
  logic                   busy, err;

  operand_stager dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .cfg_mode(cfg_mode), .a_vec(a_vec), .b_vec(b_vec),
    .is_int8_mode(is_int8_mode), .is_int4_mode(is_int4_mode), .is_vsq(is_vsq),
    .valid_mac(valid_mac), .calc_done(calc_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROWS*LANE_W-1:0] a;
    logic [LANE_W-1:0]      b;
    logic [2:0]             mode;
  } tile_t;

  typedef struct {
    logic [2:0] mode;
    int         early;
    bit         drop;
    bit         exp_err;
    logic [2:0] exp_mode;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  tile_t m_q[$];
  tile_t m_disp, m_cur;
  int    m_cnt;
  bit    m_busy, m_shown, m_err;
  logic [LANE_W-1:0] last_b;

  task automatic chk(input string name, input logic [LANE_W-1:0] act, input logic [LANE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string name, input logic [ROWS*LANE_W-1:0] act, input logic [ROWS*LANE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int r = 0; r < ROWS; r++)
        if (act[r*LANE_W +: LANE_W] !== exp[r*LANE_W +: LANE_W]) begin
          $display("FAIL %s row %0d: got %h expected %h at %0t", name, r,
                   act[r*LANE_W +: LANE_W], exp[r*LANE_W +: LANE_W], $time);
          break;
        end
    end
  endtask

  function automatic bit m_ready();
    return (m_q.size() + int'(m_busy)) < 2;
  endfunction

  function automatic bit m_launch();
    return (m_q.size() > 0) && !m_busy;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_disp = '0;
    m_cur = '0;
    m_cnt = 0;
    m_busy = 0;
    m_shown = 0;
    m_err = 0;
  endfunction

  // one clock of the tile-level model: launch oldest waiting tile, retire on calc_done, then accept the beat
  function automatic void m_step(input bit v, input logic [LANE_W-1:0] d, input bit l, input logic [2:0] m, input bit cd);
    bit rdy = m_ready();
    if (m_launch()) begin
      m_disp = m_q.pop_front();
      m_shown = 1;
      m_busy = 1;
    end else if (cd) m_busy = 0;
    if (v && rdy) begin
      if (l != (m_cnt == ROWS)) begin
        m_err = 1;
        m_cnt = 0;
      end else if (m_cnt == ROWS) begin
        m_cur.b = d;
        m_q.push_back(m_cur);
        m_cnt = 0;
      end else begin
        m_cur.a[m_cnt*LANE_W +: LANE_W] = d;
        if (m_cnt == 0) begin
          m_cur.mode = m;
          if (m[0] && m[1]) begin
            m_err = 1;
            m_cur.mode[1] = 1'b0;
          end
        end
        m_cnt++;
      end
    end
  endfunction

  task automatic check_all();
    tile_t t = '0;
    bit    ln = m_launch();
    if (ln) t = m_q[0];
    else if (m_shown) t = m_disp;
    chk("in_ready", in_ready, m_ready());
    chk("valid_mac", valid_mac, ln);
    chk("busy", busy, m_busy || ln);
    chk("err", err, m_err);
    chk("mode", {is_vsq, is_int4_mode, is_int8_mode}, t.mode);
    chk("b_vec", b_vec, t.b);
    chk_a("a_vec", a_vec, t.a);
  endtask

  task automatic cyc(input bit v, input logic [LANE_W-1:0] d, input bit l, input logic [2:0] m, input bit cd);
    in_valid = v;
    in_data = d;
    in_last = l;
    cfg_mode = m;
    calc_done = cd;
    m_step(v, d, l, m, cd);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [LANE_W-1:0] rnd_beat();
    logic [LANE_W-1:0] r = '0;
    for (int i = 0; i < 9; i++) r = {r[LANE_W-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic send_beat(input logic [LANE_W-1:0] d, input bit l, input logic [2:0] m);
    for (int n = 0; n < 100; n++) begin
      bit acc = m_ready();
      cyc(1, d, l, m, 0);
      if (acc) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL beat_accept: got no acceptance expected acceptance within 100 cycles");
  endtask

  task automatic send_tile(input bit pat, input logic [2:0] mode, input int early, input bit drop);
    logic [LANE_W-1:0] d;
    logic [7:0] k8;
    for (int k = 0; k <= ROWS; k++) begin
      k8 = 8'(k);
      d = pat ? ((k == ROWS) ? {33{8'hFF}} : {33{k8}}) : rnd_beat();
      send_beat(d, (k == early) || ((k == ROWS) && !drop), mode);
      if (k == ROWS) last_b = d;
      if (k == early) break;
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (!m_busy && m_q.size() == 0) return;
      cyc(0, '0, 0, '0, m_busy);
    end
    n_chk++;
    n_fail++;
    $display("FAIL drain: got busy expected idle within 200 cycles");
  endtask

  task automatic do_reset();
    rst_n = 0;
    in_valid = 0;
    calc_done = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    check_all();
  endtask

  vec_t tbl[7];

  initial begin
    logic [LANE_W-1:0] t2b;
    logic [2:0] rm;
    bit rl;
    tbl[0] = '{3'b001, -1, 0, 0, 3'b001};
    tbl[1] = '{3'b010, -1, 0, 0, 3'b010};
    tbl[2] = '{3'b110, -1, 0, 0, 3'b110};
    tbl[3] = '{3'b011, -1, 0, 1, 3'b001};
    tbl[4] = '{3'b111, -1, 0, 1, 3'b101};
    tbl[5] = '{3'b001,  7, 0, 1, 3'b000};
    tbl[6] = '{3'b100, -1, 1, 1, 3'b000};
    m_reset();
    @(negedge clk);
    do_reset();
    chk("reset_ready", in_ready, 1);
    chk("reset_valid", valid_mac, 0);

    // T1: single patterned tile launches the cycle after the last beat
    send_tile(1, 3'b001, -1, 0);
    chk("t1_valid", valid_mac, 1);
    chk("t1_row5", a_vec[5*LANE_W +: LANE_W], {33{8'h05}});
    chk("t1_b", b_vec, {33{8'hFF}});
    chk("t1_int8", is_int8_mode, 1);
    idle(1);
    chk("t1_pulse", valid_mac, 0);
    drain();

    // T2/T3: fill both banks, stall, then back-to-back launch on calc_done
    send_tile(0, 3'b010, -1, 0);
    send_tile(0, 3'b100, -1, 0);
    t2b = last_b;
    chk("t2_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) cyc(1, rnd_beat(), 0, 3'b001, 0);
    cyc(1, rnd_beat(), 0, 3'b001, 1);
    chk("t3_valid", valid_mac, 1);
    chk("t3_b", b_vec, t2b);
    chk("t3_vsq", is_vsq, 1);
    send_tile(0, 3'b001, -1, 0);
    drain();
    idle(2);

    // T4: early in_last discards the tile; the next good tile still launches
    send_tile(0, 3'b001, 7, 0);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    send_tile(0, 3'b010, -1, 0);
    chk("t4_valid", valid_mac, 1);
    drain();

    // T5: conflicting mode bits force int8
    send_tile(0, 3'b011, -1, 0);
    chk("t5_err", err, 1);
    chk("t5_int8", is_int8_mode, 1);
    chk("t5_int4", is_int4_mode, 0);

    // T6: asynchronous reset at beat 9 clears everything immediately
    for (int k = 0; k < 9; k++) send_beat(rnd_beat(), 0, 3'b100);
    #2 rst_n = 0;
    in_valid = 0;
    #1;
    chk("t6_ready", in_ready, 1);
    chk("t6_valid", valid_mac, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    chk("t6_mode", {is_vsq, is_int4_mode, is_int8_mode}, 0);
    chk("t6_b", b_vec, 0);
    chk_a("t6_a", a_vec, '0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    check_all();
    send_tile(0, 3'b100, -1, 0);
    chk("t6_relaunch", valid_mac, 1);
    drain();

    // table of per-tile mode/framing vectors
    for (int i = 0; i < 7; i++) begin
      do_reset();
      send_tile(0, tbl[i].mode, tbl[i].early, tbl[i].drop);
      idle(3);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_mode", i), {is_vsq, is_int4_mode, is_int8_mode}, tbl[i].exp_mode);
    end

    // random traffic checked cycle by cycle against the model
    for (int p = 0; p < 4; p++) begin
      do_reset();
      for (int n = 0; n < 1500; n++) begin
        rl = (m_cnt == ROWS);
        if ($urandom_range(0, 299) == 0) rl = !rl;
        rm = 3'($urandom_range(0, 7));
        if (rm[1:0] == 2'b11 && $urandom_range(0, 9) != 0) rm[1] = 1'b0;
        cyc($urandom_range(0, 3) != 0, rnd_beat(), rl, rm, $urandom_range(0, 7) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
